// File: rtl/wb_pkg.sv
// Shared types for the write-back buffer: register-file geometry and
// the queue entry bundle passed between wb_fifo and regfile_writeback.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of wb_entry_t: two ordered push slots, one pop.
// Ports: clk, rst_n, push0/1 enables+entries, pop, entries_o, head_o, count_o.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push0_i,
  input  wb_entry_t     push0_entry_i,
  input  logic          push1_i,
  input  wb_entry_t     push1_entry_i,
  input  logic          pop_i,
  output wb_entry_t     entries_o [DEPTH],
  output logic [PW-1:0] head_o,
  output logic [CW-1:0] count_o
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] slot;
  logic [CW-1:0] count_q, count_d;

  // push0 is the older of two same-cycle pushes, so it takes the tail
  // slot first; a lone push1 lands directly at the tail.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    slot   = tail_q;
    if (pop_i) begin
      mem_d[head_q].valid = 1'b0;
      head_d = head_q + PW'(1);
    end
    if (push0_i) begin
      mem_d[slot]       = push0_entry_i;
      mem_d[slot].valid = 1'b1;
      slot = slot + PW'(1);
    end
    if (push1_i) begin
      mem_d[slot]       = push1_entry_i;
      mem_d[slot].valid = 1'b1;
      slot = slot + PW'(1);
    end
    tail_d  = slot;
    count_d = count_q + CW'(push0_i)
            + CW'(push1_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign entries_o = mem_q;
  assign head_o    = head_q;
  assign count_o   = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back buffer: queues ALU/load results in order, drains one per cycle.
// Ports: alu*/ld* producers, wbHold, wr* regfile port, pendingMask, fwd*, empty.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [XLEN-1:0]       aluData,
  output logic                  aluReady,
  input  logic                  ldValid,
  input  logic [REG_ADDR_W-1:0] ldRd,
  input  logic [XLEN-1:0]       ldData,
  output logic                  ldReady,
  input  logic                  wbHold,
  output logic                  wrEn,
  output logic [REG_ADDR_W-1:0] wrAddr,
  output logic [XLEN-1:0]       wrData,
  output logic [NUM_REGS-1:0]   pendingMask,
  input  logic [REG_ADDR_W-1:0] fwdAddr,
  output logic                  fwdHit,
  output logic [XLEN-1:0]       fwdData,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     entries [DEPTH];
  wb_entry_t     alu_entry;
  wb_entry_t     ld_entry;
  wb_entry_t     head_entry;
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic          alu_push;
  logic          ld_push;
  logic          pop;
  logic [PW-1:0] idx;

  // Readiness looks only at the start-of-cycle count; a same-cycle
  // drain earns no credit, keeping ready off the wbHold path.
  assign aluReady = int'(count) < DEPTH;
  assign ldReady  = (int'(count) + int'(aluValid)) < DEPTH;

  // x0 results complete the handshake but are never stored.
  assign alu_push = aluValid & aluReady & (aluRd != '0);
  assign ld_push  = ldValid & ldReady & (ldRd != '0);

  assign alu_entry = '{valid: 1'b1, rd: aluRd, data: aluData};
  assign ld_entry  = '{valid: 1'b1, rd: ldRd, data: ldData};

  assign empty = (count == '0);
  assign pop   = !empty & !wbHold;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push0_i      (alu_push),
    .push0_entry_i(alu_entry),
    .push1_i      (ld_push),
    .push1_entry_i(ld_entry),
    .pop_i        (pop),
    .entries_o    (entries),
    .head_o       (head),
    .count_o      (count)
  );

  // Popped slots keep stale data, so the port is zeroed when empty.
  assign head_entry = entries[head];
  assign wrEn   = pop;
  assign wrAddr = empty ? '0 : head_entry.rd;
  assign wrData = empty ? '0 : head_entry.data;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    pendingMask = '0;
    fwdHit      = 1'b0;
    fwdData     = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries[i].valid) begin
        pendingMask[entries[i].rd] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entries[idx].valid &&
          entries[idx].rd == fwdAddr &&
          fwdAddr != '0) begin
        fwdHit  = 1'b1;
        fwdData = entries[idx].data;
      end
    end
    pendingMask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback.
// Drives on negedge, checks 1ns later; expected values hand-computed.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        aluReady;
  logic        ldValid;
  logic [4:0]  ldRd;
  logic [31:0] ldData;
  logic        ldReady;
  logic        wbHold;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [31:0] pendingMask;
  logic [4:0]  fwdAddr;
  logic        fwdHit;
  logic [31:0] fwdData;
  logic        empty;

  int total = 0;
  int bad   = 0;

  regfile_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aluValid   (aluValid),
    .aluRd      (aluRd),
    .aluData    (aluData),
    .aluReady   (aluReady),
    .ldValid    (ldValid),
    .ldRd       (ldRd),
    .ldData     (ldData),
    .ldReady    (ldReady),
    .wbHold     (wbHold),
    .wrEn       (wrEn),
    .wrAddr     (wrAddr),
    .wrData     (wrData),
    .pendingMask(pendingMask),
    .fwdAddr    (fwdAddr),
    .fwdHit     (fwdHit),
    .fwdData    (fwdData),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    aluValid = 1'b0;
    aluRd    = '0;
    aluData  = '0;
    ldValid  = 1'b0;
    ldRd     = '0;
    ldData   = '0;
    wbHold   = 1'b0;
    fwdAddr  = '0;

    // reset values
    step(); step(); #1;
    chk("rst_wrEn", 32'(wrEn), 0);
    chk("rst_wrAddr", 32'(wrAddr), 0);
    chk("rst_wrData", wrData, 0);
    chk("rst_mask", pendingMask, 0);
    chk("rst_fwdHit", 32'(fwdHit), 0);
    chk("rst_fwdData", fwdData, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aluRdy", 32'(aluReady), 1);
    chk("rst_ldRdy", 32'(ldReady), 1);
    step();
    rst_n = 1'b1;

    // single write
    step();
    aluValid = 1'b1; aluRd = 5; aluData = 32'h1234;
    #1 chk("sw_aluRdy", 32'(aluReady), 1);
    step();
    aluValid = 1'b0; fwdAddr = 5;
    #1;
    chk("sw_wrEn", 32'(wrEn), 1);
    chk("sw_wrAddr", 32'(wrAddr), 5);
    chk("sw_wrData", wrData, 32'h1234);
    chk("sw_mask", pendingMask, 32'h20);
    chk("sw_fwdHit", 32'(fwdHit), 1);
    chk("sw_fwdData", fwdData, 32'h1234);
    step(); #1;
    chk("sw_done_wrEn", 32'(wrEn), 0);
    chk("sw_done_mask", pendingMask, 0);
    chk("sw_done_empty", 32'(empty), 1);
    chk("sw_done_fwdHit", 32'(fwdHit), 0);

    // ordering: ALU older than load in same cycle
    step();
    aluValid = 1'b1; aluRd = 3; aluData = 32'hA;
    ldValid  = 1'b1; ldRd  = 3; ldData  = 32'hB;
    #1;
    chk("ord_aluRdy", 32'(aluReady), 1);
    chk("ord_ldRdy", 32'(ldReady), 1);
    step();
    aluValid = 1'b0; ldValid = 1'b0; fwdAddr = 3;
    #1;
    chk("ord_w1_en", 32'(wrEn), 1);
    chk("ord_w1_addr", 32'(wrAddr), 3);
    chk("ord_w1_data", wrData, 32'hA);
    chk("ord_w1_mask", pendingMask, 32'h8);
    chk("ord_w1_fwd", fwdData, 32'hB);
    step(); #1;
    chk("ord_w2_en", 32'(wrEn), 1);
    chk("ord_w2_data", wrData, 32'hB);
    chk("ord_w2_mask", pendingMask, 32'h8);
    chk("ord_w2_fwd", fwdData, 32'hB);
    step(); #1;
    chk("ord_end_empty", 32'(empty), 1);
    chk("ord_end_fwdHit", 32'(fwdHit), 0);
    chk("ord_end_fwdData", fwdData, 0);

    // fill under hold: rd 1..4 accepted, 5th refused
    wbHold = 1'b1;
    fwdAddr = 4;
    for (int i = 0; i < 3; i++) begin
      step();
      aluValid = 1'b1;
      aluRd = 5'(i + 1);
      aluData = 32'h100 + 32'(i);
      #1 chk("full_aluRdy", 32'(aluReady), 1);
    end
    step();
    aluRd = 4; aluData = 32'h103;
    ldValid = 1'b1; ldRd = 9; ldData = 32'h999;
    #1;
    chk("c3_aluRdy", 32'(aluReady), 1);
    chk("c3_ldRdy", 32'(ldReady), 0);
    chk("c3_hold_wrEn", 32'(wrEn), 0);
    chk("c3_hold_wrAddr", 32'(wrAddr), 1);
    chk("c3_hold_wrData", wrData, 32'h100);
    step();
    aluRd = 5; aluData = 32'h104;
    #1;
    chk("c4_aluRdy", 32'(aluReady), 0);
    chk("c4_ldRdy", 32'(ldReady), 0);
    chk("c4_mask", pendingMask, 32'h1E);
    chk("c4_fwdHit", 32'(fwdHit), 1);
    chk("c4_fwdData", fwdData, 32'h103);
    step();
    // release hold; full queue still refuses input this cycle
    ldValid = 1'b0;
    aluRd = 7; aluData = 32'h777;
    wbHold = 1'b0;
    #1 chk("rel_aluRdy", 32'(aluReady), 0);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      aluValid = 1'b0;
      #1;
      chk("drain_en", 32'(wrEn), 1);
      chk("drain_addr", 32'(wrAddr), 32'(i + 1));
      chk("drain_data", wrData, 32'h100 + 32'(i));
    end
    step(); #1;
    chk("drain_end_empty", 32'(empty), 1);
    chk("drain_end_wrEn", 32'(wrEn), 0);
    chk("drain_end_mask", pendingMask, 0);

    // x0 handshake stores nothing
    step();
    aluValid = 1'b1; aluRd = 0; aluData = 32'hFFFF;
    #1 chk("x0_aluRdy", 32'(aluReady), 1);
    step();
    aluValid = 1'b0; fwdAddr = 0;
    #1;
    chk("x0_wrEn", 32'(wrEn), 0);
    chk("x0_empty", 32'(empty), 1);
    chk("x0_mask", pendingMask, 0);
    chk("x0_fwdHit", 32'(fwdHit), 0);
    step(); #1;
    chk("x0_wrEn2", 32'(wrEn), 0);

    // async reset with 3 queued entries
    wbHold = 1'b1;
    step();
    aluValid = 1'b1; aluRd = 10; aluData = 32'hAA;
    ldValid  = 1'b1; ldRd  = 11; ldData  = 32'hBB;
    step();
    ldValid = 1'b0;
    aluRd = 12; aluData = 32'hCC;
    step();
    aluValid = 1'b0;
    wbHold = 1'b0;
    #1;
    chk("ar_pre_wrEn", 32'(wrEn), 1);
    chk("ar_pre_mask", pendingMask, 32'h1C00);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wrEn", 32'(wrEn), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_mask", pendingMask, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("ar_post_wrEn", 32'(wrEn), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
